// File: rtl/fsm_arb_pkg.sv
// Shared constants, state encoding and width helpers for the fsm_ctrl_arbiter slice.
// The optional lock/burst feature in the top level is enabled by the ARB_LOCK_EN macro.
package fsm_arb_pkg;

    localparam int ARB_N         = 4;
    localparam int ARB_W         = 32;
    localparam int ARB_MAX_BURST = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int x = 1; x < v; x = x * 2) r++;
        return r;
    endfunction

    // Register widths never drop below one bit, even for a value of 1.
    function automatic int width_of(input int v);
        return (clog2(v) < 1) ? 1 : clog2(v);
    endfunction

endpackage

// File: rtl/fsm_ctrl_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate req so the scan starts at ptr+1,
// priority-encode the lowest set bit, then un-rotate back to a requester index.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [PW-1:0] idx,
    output logic          any
);

    logic [N-1:0]  rot;
    logic [PW-1:0] off;
    logic [PW-1:0] j;
    int            start;
    int            sum;

    always_comb begin
        start = (int'(ptr) + 1) % N;
        rot   = '0;
        j     = '0;
        for (int k = 0; k < N; k++) begin
            j      = PW'((start + k) % N);
            rot[k] = req[j];
        end

        any = 1'b0;
        off = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                any = 1'b1;
                off = PW'(k);
            end
        end

        sum = (start + int'(off)) % N;
        idx = PW'(sum);

        onehot = '0;
        if (any) onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/fsm_ctrl_arbiter.sv
// Round-robin arbiter feeding one shared FSM engine through a registered valid/ready port.
// Define ARB_LOCK_EN to build the lock / zero-bubble burst path (capped at MAX_BURST transfers).
//
// state    | meaning
// ST_IDLE  | no word in flight; pick next requester from ptr+1 onward
// ST_ISSUE | granted word on ctrl_out with ctrl_vld=1, waiting for eng_rdy
module fsm_ctrl_arbiter
    import fsm_arb_pkg::*;
#(
    parameter int N         = ARB_N,
    parameter int W         = ARB_W,
    parameter int MAX_BURST = ARB_MAX_BURST
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] ctrl_in,
    input  logic [N-1:0]   lock,
    input  logic           eng_rdy,
    output logic [N-1:0]   gnt,
    output logic [W-1:0]   ctrl_out,
    output logic           ctrl_vld
);

    localparam int            PW   = width_of(N);
    localparam logic [PW-1:0] LAST = PW'(N - 1);

    state_t        state;
    logic [PW-1:0] ptr;

    logic [N-1:0]  pick_oh;
    logic [PW-1:0] pick_idx;
    logic          pick_any;
    logic [W-1:0]  win_word;

    rr_pick #(.N(N), .PW(PW)) u_pick (
        .req    (req),
        .ptr    (ptr),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    assign win_word = ctrl_in[int'(pick_idx)*W +: W];

`ifdef ARB_LOCK_EN
    localparam int BW = width_of(MAX_BURST);

    logic [BW-1:0] burst_cnt;
    logic [W-1:0]  own_word;
    logic          keep;

    // ptr equals the current winner while in ISSUE, so it doubles as the grant index.
    assign own_word = ctrl_in[int'(ptr)*W +: W];
    assign keep     = lock[ptr] & req[ptr] & (int'(burst_cnt) < MAX_BURST - 1);
`else
    logic unused_lock;
    assign unused_lock = ^lock;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            gnt      <= '0;
            ctrl_vld <= 1'b0;
            ctrl_out <= '0;
            ptr      <= LAST;
`ifdef ARB_LOCK_EN
            burst_cnt <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        state    <= ST_ISSUE;
                        gnt      <= pick_oh;
                        ctrl_out <= win_word;
                        ctrl_vld <= 1'b1;
                        ptr      <= pick_idx;
                    end
                end
                ST_ISSUE: begin
                    if (eng_rdy) begin
`ifdef ARB_LOCK_EN
                        if (keep) begin
                            ctrl_out  <= own_word;
                            burst_cnt <= burst_cnt + 1'b1;
                        end else begin
                            state     <= ST_IDLE;
                            gnt       <= '0;
                            ctrl_vld  <= 1'b0;
                            burst_cnt <= '0;
                        end
`else
                        state    <= ST_IDLE;
                        gnt      <= '0;
                        ctrl_vld <= 1'b0;
`endif
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fsm_ctrl_arbiter.sv
// Self-checking bench for fsm_ctrl_arbiter: directed vector table, lock/burst sequence
// (expectations follow ARB_LOCK_EN) and randomized traffic against a behavioural model.
module tb_fsm_ctrl_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int MB = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] ctrl_in;
    logic [N-1:0]   lock;
    logic           eng_rdy;
    logic [N-1:0]   gnt;
    logic [W-1:0]   ctrl_out;
    logic           ctrl_vld;

    int pass_cnt  = 0;
    int total_cnt = 0;

    fsm_ctrl_arbiter #(.N(N), .W(W), .MAX_BURST(MB)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .ctrl_in  (ctrl_in),
        .lock     (lock),
        .eng_rdy  (eng_rdy),
        .gnt      (gnt),
        .ctrl_out (ctrl_out),
        .ctrl_vld (ctrl_vld)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic           rst;
        logic [N-1:0]   req;
        logic [N-1:0]   lock;
        logic           rdy;
        logic [N*W-1:0] ctrl;
        logic [N-1:0]   gnt;
        logic           vld;
        logic [W-1:0]   out;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic r, input logic [N-1:0] rq, input logic rd,
                       input logic [N*W-1:0] c, input logic [N-1:0] g,
                       input logic v, input logic [W-1:0] o);
        vec_t e;
        e.rst = r; e.req = rq; e.lock = '0; e.rdy = rd; e.ctrl = c;
        e.gnt = g; e.vld = v; e.out = o;
        tv.push_back(e);
    endtask

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural reference: busy flag, winner index, held word, last winner, burst count.
    logic         m_busy;
    int           m_idx;
    int           m_last;
    int           m_burst;
    logic [W-1:0] m_out;

    function automatic logic [W-1:0] word(input int i);
        return ctrl_in[i*W +: W];
    endfunction

    task automatic model_step();
        bit found;
        if (rst) begin
            m_busy = 1'b0; m_out = '0; m_last = N - 1; m_burst = 0; m_idx = 0;
        end else if (!m_busy) begin
            found = 0;
            for (int d = 1; d <= N; d++) begin
                if (!found && req[(m_last + d) % N]) begin
                    found = 1;
                    m_idx = (m_last + d) % N;
                end
            end
            if (found) begin
                m_busy = 1'b1; m_last = m_idx; m_out = word(m_idx);
            end
        end else if (eng_rdy) begin
`ifdef ARB_LOCK_EN
            if (lock[m_idx] && req[m_idx] && m_burst < MB - 1) begin
                m_burst++; m_out = word(m_idx);
            end else begin
                m_busy = 1'b0; m_burst = 0;
            end
`else
            m_busy = 1'b0;
`endif
        end
    endtask

    logic [N*W-1:0] w0, w0b, c2, cl;
    logic [N-1:0]   exp5[8];
    logic [N-1:0]   eg;

    initial begin
        rst = 1'b1; req = '0; lock = '0; eng_rdy = 1'b0; ctrl_in = '0;
        w0  = {32'd3, 32'd9, 32'd7, 32'd5};
        w0b = {32'd3, 32'd9, 32'hDEAD, 32'd5};
        c2  = {32'd0, 32'd5, 32'd0, 32'd0};

        // reset with req asserted
        add(1, 4'hF, 1, w0, 4'h0, 0, 0);
        add(1, 4'hF, 1, w0, 4'h0, 0, 0);
        add(0, 4'h0, 1, w0, 4'h0, 0, 0);
        // single request
        add(0, 4'h4, 1, c2, 4'h4, 1, 5);
        add(0, 4'h0, 1, c2, 4'h0, 0, 5);
        // full round robin from fresh reset
        add(1, 4'h0, 1, w0, 4'h0, 0, 0);
        add(0, 4'hF, 1, w0, 4'h1, 1, 5);
        add(0, 4'hF, 1, w0, 4'h0, 0, 5);
        add(0, 4'hF, 1, w0, 4'h2, 1, 7);
        add(0, 4'hF, 1, w0, 4'h0, 0, 7);
        add(0, 4'hF, 1, w0, 4'h4, 1, 9);
        add(0, 4'hF, 1, w0, 4'h0, 0, 9);
        add(0, 4'hF, 1, w0, 4'h8, 1, 3);
        add(0, 4'hF, 1, w0, 4'h0, 0, 3);
        add(0, 4'hF, 1, w0, 4'h1, 1, 5);
        add(0, 4'h0, 1, w0, 4'h0, 0, 5);
        // backpressure; word change during hold must not leak through
        add(0, 4'h2, 0, w0,  4'h2, 1, 7);
        add(0, 4'h2, 0, w0,  4'h2, 1, 7);
        add(0, 4'h0, 0, w0b, 4'h2, 1, 7);
        add(0, 4'h0, 0, w0b, 4'h2, 1, 7);
        add(0, 4'h0, 1, w0b, 4'h0, 0, 7);
        add(0, 4'h0, 1, w0,  4'h0, 0, 7);
        // reset during ISSUE restores requester 0 priority
        add(0, 4'h3, 0, w0, 4'h1, 1, 5);
        add(1, 4'h3, 0, w0, 4'h0, 0, 0);
        add(0, 4'h3, 0, w0, 4'h1, 1, 5);
        add(0, 4'h3, 1, w0, 4'h0, 0, 5);
        add(0, 4'h3, 1, w0, 4'h2, 1, 7);
        add(0, 4'h0, 1, w0, 4'h0, 0, 7);

        #1;
        for (int i = 0; i < tv.size(); i++) begin
            rst = tv[i].rst; req = tv[i].req; lock = tv[i].lock;
            eng_rdy = tv[i].rdy; ctrl_in = tv[i].ctrl;
            tick();
            chk($sformatf("vec%0d_gnt", i), W'(gnt), W'(tv[i].gnt));
            chk($sformatf("vec%0d_vld", i), W'(ctrl_vld), W'(tv[i].vld));
            chk($sformatf("vec%0d_out", i), ctrl_out, tv[i].out);
        end

        // lock burst sequence: requester 0 locked, requester 1 competing
`ifdef ARB_LOCK_EN
        exp5 = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h2, 4'h0, 4'h1};
`else
        exp5 = '{4'h1, 4'h0, 4'h2, 4'h0, 4'h1, 4'h0, 4'h2, 4'h0};
`endif
        rst = 1'b1; req = '0; lock = '0; eng_rdy = 1'b1;
        tick();
        rst = 1'b0; req = 4'h3; lock = 4'h1;
        for (int k = 0; k < 8; k++) begin
            cl = {32'd0, 32'd0, 32'd50 + 32'(k), 32'd100 + 32'(k)};
            ctrl_in = cl;
            tick();
            chk($sformatf("lock%0d_gnt", k), W'(gnt), W'(exp5[k]));
            if (exp5[k] == 4'h1) chk($sformatf("lock%0d_out", k), ctrl_out, 32'd100 + 32'(k));
        end

        // randomized traffic against the model
        rst = 1'b1; req = '0; lock = '0; eng_rdy = 1'b0;
        model_step();
        tick();
        for (int c = 0; c < 3000; c++) begin
            rst     = ($urandom_range(0, 99) == 0);
            req     = N'($urandom);
            lock    = N'($urandom);
            eng_rdy = ($urandom_range(0, 9) < 6);
            for (int i = 0; i < N; i++) ctrl_in[i*W +: W] = $urandom;
            model_step();
            tick();
            eg = m_busy ? N'(1 << m_idx) : '0;
            chk("rand_gnt", W'(gnt), W'(eg));
            chk("rand_vld", W'(ctrl_vld), W'(m_busy));
            chk("rand_out", ctrl_out, m_out);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
